// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock frequency meter.
//   - measurement FSM state encoding
//   - settle length after enable (synchronizer flush)
//   - expected edge counts per 1 ms window for the NTSC and PAL NCO outputs
//   - tolerance helper used by the optional lock detector
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } meas_state_e;

  localparam int SETTLE_CYCLES = 3;

  localparam int NTSC_COUNT_1MS = 21477;
  localparam int PAL_COUNT_1MS  = 26602;

  // |count - expected| <= tol, evaluated in signed int arithmetic.
  function automatic logic in_tolerance(input int count, input int expected, input int tol);
    int diff;
    diff = count - expected;
    if (diff < 0) diff = -diff;
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by a third
// register for rising-edge detection.
// Ports:
//   clk      in  reference clock (clk_hi)
//   reset_n  in  synchronous active-low reset, clears all three flops
//   sig_in   in  asynchronous input
//   sig_edge out one-cycle pulse per rising edge of the synchronized input
module sync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_in,
  output logic sig_edge
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sig_edge = s2 & ~s3;

endmodule

// File: rtl/clk_freq_meter.sv
// Counts rising edges of an external square wave over a fixed gate window of
// reference clock cycles and reports the count once per window.
// Optional lock detector enabled by defining LOCK_CHECK_EN; without it
// `locked` is tied low and EXPECTED/TOLERANCE/LOCK_WINDOWS are unused.
// Ports:
//   clk        in  reference clock (clk_hi)
//   reset_n    in  synchronous active-low reset
//   en         in  measurement enable; low aborts the current window
//   sig_in     in  asynchronous square wave to measure
//   freq_count out rising edges in the last completed window
//   freq_valid out one-cycle pulse when freq_count updates
//   freq_ovf   out last completed window saturated the edge counter
//   locked     out frequency within tolerance for LOCK_WINDOWS windows
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | en low, gate and edge counters held at 0
// SETTLE  | SETTLE_CYCLES cycles, edges ignored while sync flushes
// MEASURE | gate counter running, edges counted, report on terminal
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int GATE_CYCLES  = 97500,
  parameter int COUNT_W      = 16,
  parameter int EXPECTED     = NTSC_COUNT_1MS,
  parameter int TOLERANCE    = 4,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_count,
  output logic               freq_valid,
  output logic               freq_ovf,
  output logic               locked
);

  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam logic [GATE_W-1:0]  GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
  localparam logic [1:0]         SETTLE_LOAD = 2'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX   = '1;

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_SETTLE  = SETTLE;
  localparam logic [1:0] S_MEASURE = MEASURE;

  logic [1:0]         state;
  logic [1:0]         settle_cnt;
  logic [GATE_W-1:0]  gate_cnt;
  logic [COUNT_W-1:0] edge_cnt;
  logic               ovf_flag;
  logic               sig_edge;
  logic               gate_tc;
  logic               at_max;
  logic [COUNT_W-1:0] closed_count;
  logic               closed_ovf;

  sync_edge_detect u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .sig_in   (sig_in),
    .sig_edge (sig_edge)
  );

  // Gate is a down-counter: loaded with GATE_CYCLES-1 on the first window
  // cycle, terminal when it reaches 0.
  assign gate_tc = (state == S_MEASURE) && (gate_cnt == '0);
  assign at_max  = (edge_cnt == COUNT_MAX);

  // An edge on the terminal cycle still belongs to the closing window.
  assign closed_count = (sig_edge && !at_max) ? edge_cnt + COUNT_W'(1) : edge_cnt;
  assign closed_ovf   = ovf_flag | (sig_edge & at_max);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
      freq_count <= '0;
      freq_valid <= 1'b0;
      freq_ovf   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (!en) begin
        state      <= S_IDLE;
        settle_cnt <= '0;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        ovf_flag   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
          S_SETTLE: begin
            if (settle_cnt == '0) begin
              state    <= S_MEASURE;
              gate_cnt <= GATE_LOAD;
            end else begin
              settle_cnt <= settle_cnt - 2'd1;
            end
          end
          S_MEASURE: begin
            if (gate_tc) begin
              gate_cnt   <= GATE_LOAD;
              freq_count <= closed_count;
              freq_ovf   <= closed_ovf;
              freq_valid <= 1'b1;
              edge_cnt   <= '0;
              ovf_flag   <= 1'b0;
            end else begin
              gate_cnt <= gate_cnt - GATE_W'(1);
              if (sig_edge) begin
                // Overflow means an edge was lost, not merely reaching max.
                if (at_max) ovf_flag <= 1'b1;
                else        edge_cnt <= edge_cnt + COUNT_W'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef LOCK_CHECK_EN
  localparam int LW_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [LW_W-1:0] LW_FULL = LW_W'(LOCK_WINDOWS);

  logic [LW_W-1:0] good_cnt;
  logic            window_good;

  assign window_good = !closed_ovf &&
                       in_tolerance(int'(closed_count), EXPECTED, TOLERANCE);

  // Evaluated on the terminal cycle so locked moves together with freq_valid.
  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      good_cnt <= '0;
      locked   <= 1'b0;
    end else if (gate_tc) begin
      if (!window_good) begin
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        if (good_cnt != LW_FULL) good_cnt <= good_cnt + LW_W'(1);
        locked <= (good_cnt >= LW_FULL - LW_W'(1));
      end
    end
  end
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = ^{EXPECTED, TOLERANCE, LOCK_WINDOWS};
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
module tb_clk_freq_meter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic        sig_in;

  logic [15:0] cnt_a;
  logic        val_a, ovf_a, lck_a;
  logic [3:0]  cnt_b;
  logic        val_b, ovf_b, lck_b;

  int errors = 0;
  int checks = 0;

  int period = 4;
  int ph = 0;

  typedef struct {
    bit chk;
    int cnt;
    bit good;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   lock_run = 0;

  always #5 clk = ~clk;

  clk_freq_meter #(
    .GATE_CYCLES(100), .COUNT_W(16), .EXPECTED(25), .TOLERANCE(1), .LOCK_WINDOWS(4)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .sig_in(sig_in),
    .freq_count(cnt_a), .freq_valid(val_a), .freq_ovf(ovf_a), .locked(lck_a)
  );

  clk_freq_meter #(
    .GATE_CYCLES(100), .COUNT_W(4), .EXPECTED(25), .TOLERANCE(1), .LOCK_WINDOWS(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .sig_in(sig_in),
    .freq_count(cnt_b), .freq_valid(val_b), .freq_ovf(ovf_b), .locked(lck_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Square wave generator, synchronous to clk so window counts are exact.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % period;
      sig_in = (ph < period / 2);
    end
  end

  // Scoreboard: pop one expectation per freq_valid pulse.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (val_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("unexpected_valid_a", val_a, 0);
      end else begin
        e = q_a.pop_front();
        if (e.chk) chk("count_a", cnt_a, e.cnt);
        chk("ovf_a", ovf_a, 0);
        lock_run = e.good ? ((lock_run < 4) ? lock_run + 1 : 4) : 0;
`ifdef LOCK_CHECK_EN
        chk("locked_a", lck_a, (lock_run >= 4));
`else
        chk("locked_a", lck_a, 0);
`endif
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (val_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("unexpected_valid_b", val_b, 0);
      end else begin
        e = q_b.pop_front();
        if (e.chk) begin
          chk("count_b", cnt_b, (e.cnt > 15) ? 15 : e.cnt);
          chk("ovf_b", ovf_b, (e.cnt > 15));
        end
        chk("locked_b", lck_b, 0);
      end
    end
  end

  task automatic push_exp(input bit c, input int n, input bit g);
    exp_t e;
    e.chk = c;
    e.cnt = n;
    e.good = g;
    q_a.push_back(e);
    q_b.push_back(e);
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (val_a !== 1'b1 && cyc < 400);
    chk({tag, "_valid_seen"}, val_a, 1);
  endtask

  task automatic run_windows(input int n, input int cnt, input bit c, input bit g);
    int cyc;
    for (int i = 0; i < n; i++) begin
      push_exp(c, cnt, g);
      wait_valid("window", cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count_a"}, cnt_a, 0);
    chk({tag, "_valid_a"}, val_a, 0);
    chk({tag, "_ovf_a"},   ovf_a, 0);
    chk({tag, "_locked_a"}, lck_a, 0);
    chk({tag, "_count_b"}, cnt_b, 0);
    chk({tag, "_ovf_b"},   ovf_b, 0);
  endtask

  initial begin
    int   cyc;
    logic seen;
    reset_n = 1'b0;
    en      = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // Period 4: first window latency, then steady 25 and lock on 4th valid.
    push_exp(1, 25, 1);
    en = 1'b1;
    wait_valid("first", cyc);
    chk("first_latency", cyc, 104);
    run_windows(4, 25, 1, 1);

    // Period 5 right after a report: one mixed window, then 20.
    period = 5;
    run_windows(1, 0, 0, 0);
    run_windows(2, 20, 1, 0);

    // Period 10 switched mid-window.
    push_exp(0, 0, 0);
    repeat (50) @(posedge clk);
    #1;
    period = 10;
    wait_valid("trans10", cyc);
    run_windows(2, 10, 1, 0);

    // Drop en at gate ~50: no report, outputs hold.
    repeat (50) @(posedge clk);
    #1;
    en = 1'b0;
    lock_run = 0;
    seen = 1'b0;
    repeat (150) begin
      @(posedge clk);
      #1;
      seen = seen | val_a | val_b;
    end
    chk("no_valid_after_en_drop", seen, 0);
    chk("hold_count_a", cnt_a, 10);
    chk("hold_ovf_a", ovf_a, 0);
    chk("hold_count_b", cnt_b, 10);
    chk("hold_ovf_b", ovf_b, 0);
    chk("idle_locked_a", lck_a, 0);

    push_exp(1, 10, 0);
    en = 1'b1;
    wait_valid("reenable", cyc);
    chk("reenable_latency", cyc, 104);

    // Reset at gate ~50 with en still high.
    repeat (50) @(posedge clk);
    #1;
    reset_n = 1'b0;
    lock_run = 0;
    period = 4;
    @(posedge clk);
    #1;
    chk_zero("midreset");
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_exp(1, 25, 1);
    wait_valid("after_reset", cyc);
    chk("after_reset_latency", cyc, 104);
    run_windows(3, 25, 1, 1);

    // en low clears locked immediately, count holds.
    repeat (10) @(posedge clk);
    #1;
    en = 1'b0;
    lock_run = 0;
    @(posedge clk);
    #1;
    chk("en_drop_locked_a", lck_a, 0);
    chk("en_drop_hold_count_a", cnt_a, 25);
    chk("en_drop_hold_count_b", cnt_b, 15);
    chk("en_drop_hold_ovf_b", ovf_b, 1);

    repeat (5) @(posedge clk);
    #1;
    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
